// File: rtl/ysyx_22041207_ifu_axi_rd.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_ifu_axi_rd
//   Instruction-fetch read port: turns one fetch request at a time into a
//   single-beat AXI4 read (AR then R) and holds the result until the fetch
//   side consumes it.
//
// Parameters
//   AXI_ID          constant ARID; R beats carrying another RID are dropped
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   rx_r_*          fetch request (valid/ready, 64-bit address, byte mask)
//   rx_data_*       fetch response (64-bit data, valid/ready), rx_resp_o code
//   ar*             AXI4 read-address channel (master side)
//   r*              AXI4 read-data channel (master side)
//
// Configuration
//   YSYX_22041207_IFU_ALIGN_CHECK_EN  when defined, a request whose address is
//   not aligned to its access size skips the bus and returns resp 2'b10.
// ----------------------------------------------------------------------------
module ysyx_22041207_ifu_axi_rd #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    // fetch request
    input  logic        rx_r_valid_i,
    output logic        rx_r_ready_o,
    input  logic [63:0] rx_r_addr_i,
    input  logic [7:0]  rx_r_size_i,
    // fetch response
    output logic [63:0] rx_data_read_o,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    output logic [1:0]  rx_resp_o,
    // AXI4 AR
    output logic [63:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    // AXI4 R
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_HOLD
    } state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        data_valid_q;
    logic [63:0] araddr_q;
    logic [2:0]  arsize_q;
    logic [63:0] data_q;
    logic [1:0]  resp_q;

    logic [2:0]  arsize_d;

    // Single-beat bursts only: the last flag carries no information here.
    logic        unused_rlast;
    assign unused_rlast = rlast;

    // Byte-lane mask to AXI size; unrecognised masks fall back to 8 bytes.
    always_comb begin
        arsize_d = 3'd3;
        case (rx_r_size_i)
            8'h01:   arsize_d = 3'd0;
            8'h03:   arsize_d = 3'd1;
            8'h0F:   arsize_d = 3'd2;
            8'hFF:   arsize_d = 3'd3;
            default: arsize_d = 3'd3;
        endcase
    end

`ifdef YSYX_22041207_IFU_ALIGN_CHECK_EN
    logic misaligned_d;
    always_comb begin
        misaligned_d = 1'b0;
        case (arsize_d)
            3'd1:    misaligned_d = rx_r_addr_i[0];
            3'd2:    misaligned_d = |rx_r_addr_i[1:0];
            3'd3:    misaligned_d = |rx_r_addr_i[2:0];
            default: misaligned_d = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            data_valid_q <= 1'b0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            data_q       <= '0;
            resp_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_r_valid_i && req_ready_q) begin
                        araddr_q    <= rx_r_addr_i;
                        arsize_q    <= arsize_d;
                        req_ready_q <= 1'b0;
`ifdef YSYX_22041207_IFU_ALIGN_CHECK_EN
                        if (misaligned_d) begin
                            state_q      <= S_HOLD;
                            data_q       <= '0;
                            resp_q       <= 2'b10;
                            data_valid_q <= 1'b1;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                        end
`else
                        state_q   <= S_AR;
                        arvalid_q <= 1'b1;
`endif
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    // rready is high throughout R, so any rvalid is a transfer;
                    // foreign-ID beats are consumed but not captured.
                    if (rvalid && (rid == AXI_ID)) begin
                        rready_q     <= 1'b0;
                        data_valid_q <= 1'b1;
                        resp_q       <= rresp;
                        data_q       <= (rresp != 2'b00) ? '0 : rdata;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rx_data_ready) begin
                        data_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_r_ready_o   = req_ready_q;
    assign rx_data_read_o = data_q;
    assign rx_data_valid  = data_valid_q;
    assign rx_resp_o      = resp_q;
    assign araddr         = araddr_q;
    assign arvalid        = arvalid_q;
    assign arid           = AXI_ID;
    assign arlen          = '0;
    assign arsize         = arsize_q;
    assign arburst        = 2'b01;
    assign rready         = rready_q;

endmodule

// File: tb/tb_ysyx_22041207_ifu_axi_rd.sv
module tb_ysyx_22041207_ifu_axi_rd;

    localparam logic [3:0] ID = 4'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_r_valid_i;
    logic        rx_r_ready_o;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic [63:0] rx_data_read_o;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [1:0]  rx_resp_o;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rready;

    ysyx_22041207_ifu_axi_rd #(.AXI_ID(ID)) dut (
        .clk(clk), .rst(rst),
        .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
        .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
        .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .rx_resp_o(rx_resp_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each completed response handshake pops one entry.
    always @(negedge clk) begin
        if (!rst && rx_data_valid && rx_data_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_response", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_data", rx_data_read_o, e.d);
                chk("sb_resp", {62'd0, rx_resp_o}, {62'd0, e.r});
            end
        end
    end

    task automatic do_fetch(input logic [63:0] a, input logic [7:0] m,
                            input int ar_dly, input bit bad_rid,
                            input logic [1:0] rr, input logic [63:0] rd,
                            input int hold_dly, input bit early_rdy,
                            input logic [2:0] exp_sz,
                            input logic [63:0] exp_d, input logic [1:0] exp_r);
        exp_t e;
        rx_r_valid_i  = 1'b1;
        rx_r_addr_i   = a;
        rx_r_size_i   = m;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rx_data_ready = early_rdy;
        tick();
        // A second, different request stays pending while busy.
        rx_r_addr_i = 64'hBAD0_0000_0000_0000;
        rx_r_size_i = 8'h01;
        chk("ar_valid", {63'd0, arvalid}, 64'd1);
        chk("ar_addr", araddr, a);
        chk("ar_size", {61'd0, arsize}, {61'd0, exp_sz});
        chk("ar_len_burst_id", {50'd0, arlen, arburst, arid}, {50'd0, 8'd0, 2'b01, ID});
        chk("req_ready_busy", {63'd0, rx_r_ready_o}, 64'd0);
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            chk("ar_valid_stable", {63'd0, arvalid}, 64'd1);
            chk("ar_addr_stable", araddr, a);
            chk("req_ready_wait", {63'd0, rx_r_ready_o}, 64'd0);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r_ready", {63'd0, rready}, 64'd1);
        chk("ar_drop", {63'd0, arvalid}, 64'd0);
        chk("no_early_valid", {63'd0, rx_data_valid}, 64'd0);
        if (bad_rid) begin
            rvalid = 1'b1;
            rid    = 4'd3;
            rdata  = 64'hFFFF_0000_FFFF_0000;
            rresp  = 2'b00;
            tick();
            chk("bad_rid_stay_r", {63'd0, rready}, 64'd1);
            chk("bad_rid_no_valid", {63'd0, rx_data_valid}, 64'd0);
        end
        rvalid = 1'b1;
        rid    = ID;
        rdata  = rd;
        rresp  = rr;
        rlast  = 1'b1;
        e.d = exp_d;
        e.r = exp_r;
        q.push_back(e);
        tick();
        rvalid = 1'b0;
        chk("hold_valid", {63'd0, rx_data_valid}, 64'd1);
        chk("hold_rready_low", {63'd0, rready}, 64'd0);
        if (!early_rdy) begin
            for (int i = 0; i < hold_dly; i++) begin
                tick();
                chk("hold_stable_valid", {63'd0, rx_data_valid}, 64'd1);
                chk("hold_stable_data", rx_data_read_o, exp_d);
                chk("hold_req_ready", {63'd0, rx_r_ready_o}, 64'd0);
            end
        end
        rx_r_valid_i  = 1'b0;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        chk("idle_valid_low", {63'd0, rx_data_valid}, 64'd0);
        chk("idle_req_ready", {63'd0, rx_r_ready_o}, 64'd1);
        chk("idle_arvalid_low", {63'd0, arvalid}, 64'd0);
        chk("idle_data_held", rx_data_read_o, exp_d);
        chk("idle_resp_held", {62'd0, rx_resp_o}, {62'd0, exp_r});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rx_r_valid_i = 1'b0; rx_r_addr_i = '0; rx_r_size_i = '0;
        rx_data_ready = 1'b0; arready = 1'b0;
        rdata = '0; rresp = '0; rlast = 1'b0; rid = '0; rvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_dvalid", {63'd0, rx_data_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, rx_r_ready_o}, 64'd1);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_data", rx_data_read_o, 64'd0);
        chk("rst_resp", {62'd0, rx_resp_o}, 64'd0);

        // Minimum latency fetch, then ready held high before HOLD.
        do_fetch(64'h8000_0000, 8'h0F, 0, 1'b0, 2'b00, 64'h0000_0413, 0, 1'b0,
                 3'd2, 64'h0000_0413, 2'b00);
        do_fetch(64'h8000_0010, 8'h0F, 0, 1'b0, 2'b00, 64'h0000_0513, 0, 1'b1,
                 3'd2, 64'h0000_0513, 2'b00);
        // Stalled AR and stalled consumer.
        do_fetch(64'h8000_0100, 8'hFF, 5, 1'b0, 2'b00, 64'h1122_3344_5566_7788, 4, 1'b0,
                 3'd3, 64'h1122_3344_5566_7788, 2'b00);
        // Error response masks data.
        do_fetch(64'h8000_0008, 8'h0F, 0, 1'b0, 2'b10, 64'hDEAD_BEEF, 1, 1'b0,
                 3'd2, 64'h0, 2'b10);
        // Foreign ID beat discarded.
        do_fetch(64'h8000_0020, 8'h0F, 1, 1'b1, 2'b00, 64'h13, 0, 1'b0,
                 3'd2, 64'h13, 2'b00);
        // Remaining size encodings, including an unrecognised mask.
        do_fetch(64'h8000_0040, 8'h01, 0, 1'b0, 2'b00, 64'hA1, 0, 1'b0, 3'd0, 64'hA1, 2'b00);
        do_fetch(64'h8000_0040, 8'h03, 0, 1'b0, 2'b00, 64'hA2, 0, 1'b0, 3'd1, 64'hA2, 2'b00);
        do_fetch(64'h8000_0040, 8'h55, 0, 1'b0, 2'b00, 64'hA3, 0, 1'b0, 3'd3, 64'hA3, 2'b00);

        // Reset while waiting in R abandons the transaction.
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h8000_0030;
        rx_r_size_i  = 8'h0F;
        arready      = 1'b1;
        tick();
        rx_r_valid_i = 1'b0;
        tick();
        arready = 1'b0;
        chk("pre_rst_in_r", {63'd0, rready}, 64'd1);
        rst    = 1'b1;
        rvalid = 1'b1;
        rid    = ID;
        rdata  = 64'h7777;
        tick();
        rst    = 1'b0;
        rvalid = 1'b0;
        chk("rst_r_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_r_rready", {63'd0, rready}, 64'd0);
        chk("rst_r_dvalid", {63'd0, rx_data_valid}, 64'd0);
        chk("rst_r_req_ready", {63'd0, rx_r_ready_o}, 64'd1);
        chk("rst_r_data", rx_data_read_o, 64'd0);
        do_fetch(64'h8000_0004, 8'h0F, 0, 1'b0, 2'b00, 64'h13, 0, 1'b0,
                 3'd2, 64'h13, 2'b00);

`ifdef YSYX_22041207_IFU_ALIGN_CHECK_EN
        begin
            exp_t e;
            rx_r_valid_i = 1'b1;
            rx_r_addr_i  = 64'h8000_0002;
            rx_r_size_i  = 8'h0F;
            e.d = 64'h0;
            e.r = 2'b10;
            q.push_back(e);
            tick();
            rx_r_valid_i = 1'b0;
            chk("misalign_no_ar", {63'd0, arvalid}, 64'd0);
            chk("misalign_hold", {63'd0, rx_data_valid}, 64'd1);
            rx_data_ready = 1'b1;
            tick();
            rx_data_ready = 1'b0;
            chk("misalign_idle", {63'd0, rx_data_valid}, 64'd0);
            chk("misalign_arvalid", {63'd0, arvalid}, 64'd0);
        end
`else
        do_fetch(64'h8000_0002, 8'h0F, 0, 1'b0, 2'b00, 64'h99, 0, 1'b0,
                 3'd2, 64'h99, 2'b00);
`endif

        tick();
        tick();
        chk("sb_drained", q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
